// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - d_cache port arbiter between MEM stage and external loader/debug port
// Core wins collisions until it has taken MAXCORE grants back to back, then external wins one.
module dmem_arbiter #(
  parameter int DPW     = 32,
  parameter int MAXCORE = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           core_req,
  input  logic           core_we,
  input  logic [DPW-1:0] core_addr,
  input  logic [DPW-1:0] core_wd,
  output logic           core_stall,
  output logic [DPW-1:0] core_rd,
  input  logic           ext_valid,
  input  logic           ext_we,
  input  logic [DPW-1:0] ext_addr,
  input  logic [DPW-1:0] ext_wd,
  output logic           ext_ready,
  output logic [DPW-1:0] ext_rdata,
  output logic           ext_rvalid,
  output logic [DPW-1:0] mem_addr,
  output logic [DPW-1:0] mem_wd,
  output logic           mem_we,
  input  logic [DPW-1:0] mem_rd,
  output logic [1:0]     grant
);

  localparam int CW = (MAXCORE < 1) ? 1 : $clog2(MAXCORE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAXCORE);

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CORE = 2'b01;
  localparam logic [1:0] GNT_EXT  = 2'b10;

  logic [CW-1:0] starve_cnt;
  logic          at_limit;

  // With MAXCORE=0 the counter never leaves 0, so the external side always wins.
  assign at_limit = (starve_cnt == CNT_MAX);

  always_comb begin
    grant = GNT_NONE;
    if (!rst) begin
      if (ext_valid && (!core_req || at_limit)) begin
        grant = GNT_EXT;
      end else if (core_req) begin
        grant = GNT_CORE;
      end
    end
  end

  always_comb begin
    mem_addr = '0;
    mem_wd   = '0;
    mem_we   = 1'b0;
    case (grant)
      GNT_CORE: begin
        mem_addr = core_addr;
        mem_wd   = core_wd;
        mem_we   = core_we;
      end
      GNT_EXT: begin
        mem_addr = ext_addr;
        mem_wd   = ext_wd;
        mem_we   = ext_we;
      end
      default: ;
    endcase
  end

  assign core_stall = core_req && !rst && (grant != GNT_CORE);
  assign core_rd    = mem_rd;
  assign ext_ready  = (grant == GNT_EXT);

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant == GNT_EXT || !ext_valid) begin
      starve_cnt <= '0;
    end else if (grant == GNT_CORE && !at_limit) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // External read data is captured from the cache on the accepting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_rdata  <= '0;
      ext_rvalid <= 1'b0;
    end else if (ext_valid && ext_ready && !ext_we) begin
      ext_rdata  <= mem_rd;
      ext_rvalid <= 1'b1;
    end else begin
      ext_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized bench for dmem_arbiter, MAXCORE=4 and MAXCORE=0 side by side
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, ext_valid, ext_we;
  logic [31:0] core_addr, core_wd, ext_addr, ext_wd;

  logic        core_stall_4, ext_ready_4, ext_rvalid_4, mem_we_4;
  logic [31:0] core_rd_4, ext_rdata_4, mem_addr_4, mem_wd_4, mem_rd_4;
  logic [1:0]  grant_4;
  logic        core_stall_0, ext_ready_0, ext_rvalid_0, mem_we_0;
  logic [31:0] core_rd_0, ext_rdata_0, mem_addr_0, mem_wd_0, mem_rd_0;
  logic [1:0]  grant_0;

  logic [31:0] dm4 [64];
  logic [31:0] dm0 [64];

  int n_vec = 0;
  int n_err = 0;

  int          maxc [2] = '{4, 0};
  int          run [2];
  logic        exp_rv [2];
  logic [31:0] exp_rdat [2];
  logic [31:0] ref_mem [2][64];
  logic        hold_core, hold_ext;

  always #5 clk = ~clk;

  dmem_arbiter #(.DPW(32), .MAXCORE(4)) u4 (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wd(core_wd),
    .core_stall(core_stall_4), .core_rd(core_rd_4),
    .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wd(ext_wd),
    .ext_ready(ext_ready_4), .ext_rdata(ext_rdata_4), .ext_rvalid(ext_rvalid_4),
    .mem_addr(mem_addr_4), .mem_wd(mem_wd_4), .mem_we(mem_we_4), .mem_rd(mem_rd_4),
    .grant(grant_4)
  );

  dmem_arbiter #(.DPW(32), .MAXCORE(0)) u0 (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wd(core_wd),
    .core_stall(core_stall_0), .core_rd(core_rd_0),
    .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wd(ext_wd),
    .ext_ready(ext_ready_0), .ext_rdata(ext_rdata_0), .ext_rvalid(ext_rvalid_0),
    .mem_addr(mem_addr_0), .mem_wd(mem_wd_0), .mem_we(mem_we_0), .mem_rd(mem_rd_0),
    .grant(grant_0)
  );

  // Small d_cache stand-ins: combinational read, write on the clock edge.
  assign mem_rd_4 = dm4[mem_addr_4[7:2]];
  assign mem_rd_0 = dm0[mem_addr_0[7:2]];
  always @(posedge clk) if (mem_we_4) dm4[mem_addr_4[7:2]] <= mem_wd_4;
  always @(posedge clk) if (mem_we_0) dm0[mem_addr_0[7:2]] <= mem_wd_0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom_range(0, 15);
    return a << 2;
  endfunction

  // Called with inputs freshly driven just after a falling edge; checks, advances the model,
  // then waits for the next falling edge.
  task automatic cycle();
    logic [1:0]  eg, dg;
    logic [31:0] ea, ew;
    logic        ewe;
    logic        d_we, d_stall, d_ready, d_rv;
    logic [31:0] d_addr, d_wd, d_rd, d_rdat;
    string       s;
    #1;
    hold_core = 1'b0;
    hold_ext  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s = (k == 0) ? "m4" : "m0";
      dg      = (k == 0) ? grant_4      : grant_0;
      d_we    = (k == 0) ? mem_we_4     : mem_we_0;
      d_addr  = (k == 0) ? mem_addr_4   : mem_addr_0;
      d_wd    = (k == 0) ? mem_wd_4     : mem_wd_0;
      d_stall = (k == 0) ? core_stall_4 : core_stall_0;
      d_ready = (k == 0) ? ext_ready_4  : ext_ready_0;
      d_rv    = (k == 0) ? ext_rvalid_4 : ext_rvalid_0;
      d_rdat  = (k == 0) ? ext_rdata_4  : ext_rdata_0;
      d_rd    = (k == 0) ? core_rd_4    : core_rd_0;

      if (rst) eg = 2'd0;
      else if (ext_valid && (!core_req || run[k] >= maxc[k])) eg = 2'd2;
      else if (core_req) eg = 2'd1;
      else eg = 2'd0;

      ea = 0; ew = 0; ewe = 0;
      if (eg == 2'd1) begin ea = core_addr; ew = core_wd; ewe = core_we; end
      if (eg == 2'd2) begin ea = ext_addr;  ew = ext_wd;  ewe = ext_we;  end

      check({s, "_grant"}, dg, eg);
      check({s, "_mem_we"}, d_we, ewe);
      check({s, "_mem_addr"}, d_addr, ea);
      check({s, "_mem_wd"}, d_wd, ew);
      check({s, "_core_stall"}, d_stall, core_req && !rst && eg != 2'd1);
      check({s, "_ext_ready"}, d_ready, eg == 2'd2);
      check({s, "_ext_rvalid"}, d_rv, exp_rv[k]);
      check({s, "_ext_rdata"}, d_rdat, exp_rdat[k]);
      if (eg == 2'd1 && !core_we)
        check({s, "_core_rd"}, d_rd, ref_mem[k][core_addr[7:2]]);

      if (rst) begin
        run[k] = 0; exp_rv[k] = 0; exp_rdat[k] = 0;
      end else begin
        if (eg == 2'd2 && !ext_we) begin
          exp_rv[k] = 1; exp_rdat[k] = ref_mem[k][ext_addr[7:2]];
        end else begin
          exp_rv[k] = 0;
        end
        if (eg == 2'd2 || !ext_valid) run[k] = 0;
        else if (eg == 2'd1 && run[k] < maxc[k]) run[k]++;
        if (core_req && eg != 2'd1) hold_core = 1'b1;
        if (ext_valid && eg != 2'd2) hold_ext = 1'b1;
      end
      if (ewe) ref_mem[k][ea[7:2]] = ew;
    end
    @(negedge clk);
  endtask

  int pat [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

  initial begin
    for (int i = 0; i < 64; i++) begin
      dm4[i] = 0; dm0[i] = 0; ref_mem[0][i] = 0; ref_mem[1][i] = 0;
    end
    for (int k = 0; k < 2; k++) begin run[k] = 0; exp_rv[k] = 0; exp_rdat[k] = 0; end
    hold_core = 0; hold_ext = 0;
    rst = 1; core_req = 1; core_we = 1; core_addr = 32'h4; core_wd = 32'h55;
    ext_valid = 1; ext_we = 1; ext_addr = 32'h8; ext_wd = 32'h66;
    @(negedge clk);

    // reset with both sides requesting
    cycle();
    cycle();

    // ext preload, then core load of the same word
    rst = 0; core_req = 0; ext_valid = 1; ext_we = 1; ext_addr = 32'h10; ext_wd = 32'h0000_00AA;
    #1 check("pre_ext_ready", ext_ready_4, 1);
    cycle();
    ext_valid = 0; core_req = 1; core_we = 0; core_addr = 32'h10;
    #1 check("load_core_rd", core_rd_4, 32'h0000_00AA);
    check("load_stall", core_stall_4, 0);
    cycle();

    // core store, then ext read
    core_we = 1; core_addr = 32'h20; core_wd = 32'h1234_5678;
    cycle();
    core_req = 0; ext_valid = 1; ext_we = 0; ext_addr = 32'h20;
    #1 check("rd_ext_ready", ext_ready_4, 1);
    cycle();
    ext_valid = 0;
    #1 check("rd_rvalid", ext_rvalid_4, 1);
    check("rd_rdata", ext_rdata_4, 32'h1234_5678);
    cycle();

    // starvation bound; MAXCORE=0 instance always hands the collision to ext
    core_req = 1; core_we = 0; core_addr = 32'h0;
    ext_valid = 1; ext_we = 0; ext_addr = 32'h10;
    for (int i = 0; i < 10; i++) begin
      #1 check("starve_grant", grant_4, pat[i]);
      check("starve_stall", core_stall_4, pat[i] == 2);
      check("m0_collide_grant", grant_0, 2);
      check("m0_collide_stall", core_stall_0, 1);
      check("m0_collide_we", mem_we_0, ext_we);
      cycle();
    end
    ext_valid = 0;
    #1 check("m0_release_grant", grant_0, 1);
    cycle();

    // reset right after an ext read is granted, then re-issue
    core_req = 0; ext_valid = 1; ext_we = 0; ext_addr = 32'h20;
    cycle();
    rst = 1; ext_valid = 0;
    cycle();
    rst = 0;
    #1 check("rst_rvalid", ext_rvalid_4, 0);
    cycle();
    ext_valid = 1;
    cycle();
    ext_valid = 0;
    #1 check("reissue_rvalid", ext_rvalid_4, 1);
    check("reissue_rdata", ext_rdata_4, 32'h1234_5678);
    cycle();

    // random traffic honouring the hold-while-stalled rules
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      if (!hold_core || rst) begin
        core_req  = $urandom_range(0, 3) != 0;
        core_we   = $urandom_range(0, 1);
        core_addr = rand_addr();
        core_wd   = $urandom;
      end
      if (!hold_ext || rst) begin
        ext_valid = $urandom_range(0, 1);
        ext_we    = $urandom_range(0, 1);
        ext_addr  = rand_addr();
        ext_wd    = $urandom;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
